uart_tx_framer: RTL and testbench
=================================

Name: uart_tx_framer

Overview:
- Upstream feeder for the UART byte transmitter.
- Buffers 16-bit sample words in a FIFO and frames them into fixed-length packets: sync, sequence, payload, checksum.
- Issues the packet bytes one at a time over the transmitter's tx_data/tx_valid/tx_ready handshake.
- Byte handshake is confirmed by tx_ready falling, which tolerates a transmitter that captures valid one cycle late.

Parameters:
- DEPTH, 16: FIFO depth in 16-bit words. Power of two, >= PKT_WORDS.
- PKT_WORDS, 4: words per packet. Range 1..63.
- SYNC_BYTE, 8'hA5: first byte of every packet.
- ACK_TIMEOUT, 1024: cycles to wait for tx_ready to fall after a tx_valid pulse before re-issuing the byte.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_data  in  16  sample word.
- in_valid  in  1  in_data valid.
- in_ready  out  1  FIFO can accept a word (= !full).
- tx_data  out  8  byte to transmitter.
- tx_valid  out  1  single-cycle byte request.
- tx_ready  in  1  transmitter idle/ready.
- fifo_level  out  $clog2(DEPTH)+1  words currently stored.
- overflow  out  1  sticky: write attempted while full.
- busy  out  1  packet in progress (state != IDLE).
- pkt_count  out  16  packets completed, wraps at 65535 -> 0.

Behaviour:
- Reset values: in_ready=1, tx_data=0, tx_valid=0, fifo_level=0, overflow=0, busy=0, pkt_count=0, seq=0. FIFO is emptied and the FSM returns to IDLE.
- Reset mid-packet abandons the packet. No further bytes are issued.
- FIFO push:
  - A push occurs when in_valid && in_ready.
  - in_ready depends only on full. When full, a same-cycle pop does not enable a push.
  - in_valid && !in_ready sets overflow. Only rst clears it.
  - The word is dropped.
- fifo_level counts +1 on push, -1 on pop, unchanged when both occur. Read and write pointers wrap modulo DEPTH.
- Packet byte order:
  - SYNC_BYTE.
  - seq.
  - For each word: high byte, then low byte.
  - CHK = 8-bit modulo-256 sum of seq and all payload bytes. SYNC_BYTE is excluded.
- Packet FSM:
  - IDLE: when fifo_level >= PKT_WORDS, latch seq, clear the sum accumulator, go to SYNC. Transition takes one cycle; busy=1 from the next cycle.
  - SYNC -> SEQ -> PAY -> CHK -> IDLE. Each state advances only after its byte is acknowledged.
  - PAY pops one FIFO word into a 16-bit hold register when starting a word's high byte. It runs 2*PKT_WORDS bytes.
  - Underflow is impossible: the packet starts only when all words are present.
  - CHK acknowledged: seq <= seq+1 (wraps 255 -> 0), pkt_count <= pkt_count+1, state IDLE.
- Byte handshake, a sub-FSM per byte:
  - ISSUE: tx_data is driven with the byte. When tx_ready==1, assert tx_valid for exactly one cycle, then go to WAIT_ACK.
  - WAIT_ACK:
    - tx_data is held stable and tx_valid=0.
    - tx_ready==0 observed means the byte is accepted. Advance to the next byte's ISSUE.
    - The next ISSUE waits for tx_ready==1 again before pulsing.
  - Timeout: if tx_ready stays 1 for ACK_TIMEOUT cycles in WAIT_ACK, return to ISSUE and re-pulse the same byte.
  - A duplicate byte on the line after a timeout is accepted behaviour.
- tx_valid is never high on two consecutive cycles. tx_data changes only in ISSUE before the pulse.
- Minimum spacing between tx_valid pulses is 3 cycles.

Test Plan:
- Single packet:
  - Stimulus: push 0x1234, 0x5678, 0x9ABC, 0xDEF0. Transmitter model drops tx_ready one cycle after valid and holds it low 10 cycles.
  - Required bytes: A5 00 12 34 56 78 9A BC DE F0 38.
  - Then pkt_count=1, fifo_level=0, busy=0.
- Partial fill:
  - Stimulus: push 3 words.
  - Required: no tx_valid for 1000 cycles, fifo_level=3. The 4th push starts the packet, with tx_valid following the A5 pulse within 3 cycles.
- Overflow:
  - Stimulus: hold tx_ready=0, push 17 words.
  - Required: in_ready=0 after the 16th, overflow=1, fifo_level=16. The 17th word never appears.
- Timeout retry:
  - Stimulus: tx_ready held 1 after the first pulse.
  - Required: tx_valid re-pulses with data A5 exactly ACK_TIMEOUT cycles after WAIT_ACK entry.
- Sequence wrap:
  - Stimulus: send 257 packets.
  - Required: the seq byte of packet 256 is 0xFF and of packet 257 is 0x00. pkt_count=257.
- Reset mid-packet:
  - Stimulus: assert rst after the 4th byte of a packet.
  - Required: outputs return to reset values next cycle, no further tx_valid. The next packet starts with seq 0x00.

Source files
------------

// File: rtl/uart_tx_framer.sv
// uart_tx_framer: buffers 16-bit sample words in a FIFO and frames them into
// fixed-length packets (sync, sequence, payload, checksum). Packet bytes go
// one at a time to the UART byte transmitter.
//
// Byte handshake with the transmitter:
//   tx_data is loaded while the byte is being issued. Once tx_ready is seen
//   high, tx_valid is raised for exactly one cycle. The byte counts as taken
//   only when tx_ready is later seen low, which tolerates a transmitter that
//   samples tx_valid a cycle late. tx_data holds still until that happens.
//   If tx_ready never falls within ACK_TIMEOUT cycles, the same byte is
//   pulsed again, so a duplicate byte on the line is possible.
module uart_tx_framer #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned PKT_WORDS   = 4,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int unsigned ACK_TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [15:0]              in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  output logic                     busy,
  output logic [15:0]              pkt_count,
  output logic [3:0]               dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
  localparam logic [LW-1:0] PKT_LVL   = LW'(PKT_WORDS);
  localparam logic [6:0]    LAST_IDX  = 7'(2 * PKT_WORDS - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_SEQ, S_PAY, S_CHK} pkt_state_e;
  typedef enum logic {PH_ISSUE, PH_WAIT} phase_e;

  pkt_state_e    state_q, state_d;
  phase_e        phase_q, phase_d;
  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic [7:0]    seq_q, seq_d;
  logic [7:0]    sum_q, sum_d;
  logic [6:0]    byte_idx_q, byte_idx_d;
  logic [15:0]   hold_q, hold_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [15:0]   pkt_count_q, pkt_count_d;
  logic          full, push, pop;
  logic [7:0]    cur_byte;

  // FIFO status; a pop in the same cycle never frees a slot for a push when full.
  assign full = (level_q == FULL_LVL);
  assign push = in_valid && !full;

  // Byte currently owed to the transmitter, selected by packet state.
  always_comb begin
    cur_byte = 8'h00;
    case (state_q)
      S_SYNC:  cur_byte = SYNC_BYTE;
      S_SEQ:   cur_byte = seq_q;
      S_PAY:   cur_byte = byte_idx_q[0] ? hold_q[7:0] : hold_q[15:8];
      S_CHK:   cur_byte = sum_q;
      default: cur_byte = 8'h00;
    endcase
  end

  // Next-state logic for the packet FSM, byte handshake and FIFO bookkeeping.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = 1'b0;
    seq_d       = seq_q;
    sum_d       = sum_q;
    byte_idx_d  = byte_idx_q;
    hold_d      = hold_q;
    tmo_d       = tmo_q;
    pkt_count_d = pkt_count_q;
    pop         = 1'b0;

    if (state_q == S_IDLE) begin
      // Start only when a whole packet's worth of words is buffered.
      if (level_q >= PKT_LVL) begin
        state_d = S_SYNC;
        phase_d = PH_ISSUE;
        sum_d   = 8'h00;
      end
    end else if (phase_q == PH_ISSUE) begin
      tx_data_d = cur_byte;
      if (tx_ready) begin
        tx_valid_d = 1'b1;
        phase_d    = PH_WAIT;
        tmo_d      = '0;
      end
    end else begin
      if (!tx_ready) begin
        // Byte accepted: move on to the next byte of the packet.
        phase_d = PH_ISSUE;
        case (state_q)
          S_SYNC: state_d = S_SEQ;
          S_SEQ: begin
            sum_d      = sum_q + tx_data_q;
            state_d    = S_PAY;
            byte_idx_d = 7'd0;
            pop        = 1'b1;
            hold_d     = mem_q[rd_ptr_q];
          end
          S_PAY: begin
            sum_d = sum_q + tx_data_q;
            if (byte_idx_q == LAST_IDX) begin
              state_d = S_CHK;
            end else begin
              byte_idx_d = byte_idx_q + 7'd1;
              // Low byte done: the next byte is a new word's high byte.
              if (byte_idx_q[0]) begin
                pop    = 1'b1;
                hold_d = mem_q[rd_ptr_q];
              end
            end
          end
          S_CHK: begin
            seq_d       = seq_q + 8'd1;
            pkt_count_d = pkt_count_q + 16'd1;
            state_d     = S_IDLE;
          end
          default: state_d = S_IDLE;
        endcase
      end else if (tmo_q == TMO_LAST) begin
        // No acknowledge: go back and pulse the same byte again.
        phase_d = PH_ISSUE;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end

    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d    = level_q + LW'(push) - LW'(pop);
    overflow_d = overflow_q || (in_valid && full);
  end

  // FIFO storage; contents need no reset because level gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      phase_q     <= PH_ISSUE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      tx_valid_q  <= 1'b0;
      seq_q       <= 8'h00;
      sum_q       <= 8'h00;
      byte_idx_q  <= 7'd0;
      hold_q      <= 16'h0000;
      tmo_q       <= '0;
      pkt_count_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      seq_q       <= seq_d;
      sum_q       <= sum_d;
      byte_idx_q  <= byte_idx_d;
      hold_q      <= hold_d;
      tmo_q       <= tmo_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  assign in_ready   = !full;
  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign fifo_level = level_q;
  assign overflow   = overflow_q;
  assign busy       = (state_q != S_IDLE);
  assign pkt_count  = pkt_count_q;
  assign dbg_state  = {phase_q, state_q};

endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for uart_tx_framer: directed packets against hand-computed byte
// streams, partial fill, overflow, acknowledge timeout, reset mid-packet and
// sequence-number wrap.
module tb_uart_tx_framer;

  localparam int DEPTH       = 16;
  localparam int PKT_WORDS   = 4;
  localparam int ACK_TIMEOUT = 1024;
  localparam int M_NORMAL = 0, M_HOLD1 = 1, M_HOLD0 = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in_data = 16'h0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [4:0]  fifo_level;
  logic        overflow;
  logic        busy;
  logic [15:0] pkt_count;
  logic [3:0]  dbg_state;

  uart_tx_framer #(
    .DEPTH(DEPTH), .PKT_WORDS(PKT_WORDS), .SYNC_BYTE(8'hA5), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .fifo_level(fifo_level), .overflow(overflow), .busy(busy),
    .pkt_count(pkt_count), .dbg_state(dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  logic       sb_en = 1'b1;
  int         n_pulses = 0;
  int         last_pulse_cyc = 0;
  logic       have_last = 1'b0;
  logic [7:0] pulse_data = 8'h0;
  logic [7:0] last_seq = 8'h0;
  int         byte_pos = 0;
  int         tx_mode = M_NORMAL;
  int         low_len = 10;
  logic [15:0] pkt_words[PKT_WORDS];

  logic [7:0] single_exp[11] = '{8'hA5, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78,
                                 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h38};
  logic [7:0] partial_exp[11] = '{8'hA5, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04,
                                  8'h05, 8'h06, 8'h07, 8'h08, 8'h25};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Expected bytes for one packet built from pkt_words.
  task automatic sb_load_pkt(input logic [7:0] seq);
    logic [7:0] sum;
    sum = seq;
    exp_q.push_back(8'hA5);
    exp_q.push_back(seq);
    for (int i = 0; i < PKT_WORDS; i++) begin
      exp_q.push_back(pkt_words[i][15:8]);
      exp_q.push_back(pkt_words[i][7:0]);
      sum = sum + pkt_words[i][15:8] + pkt_words[i][7:0];
    end
    exp_q.push_back(sum);
  endtask

  // ---------------- monitor: every tx_valid pulse ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        byte_pos  = 0;
        have_last = 1'b0;
      end else if (tx_valid) begin
        if (have_last) check("pulse_gap", 32'((cyc - last_pulse_cyc) >= 3), 32'd1);
        have_last      = 1'b1;
        last_pulse_cyc = cyc;
        pulse_data     = tx_data;
        n_pulses++;
        if (byte_pos == 1) last_seq = tx_data;
        byte_pos = (byte_pos == 2 * PKT_WORDS + 2) ? 0 : byte_pos + 1;
        if (sb_en) begin
          if (exp_q.size() == 0) check("sb_extra_byte", 32'd1, 32'd0);
          else check("sb_byte", 32'(tx_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // ---------------- transmitter model ----------------
  // NORMAL: tx_ready drops the cycle after a pulse and stays low low_len cycles.
  initial begin
    logic pend;
    int   low_cnt;
    pend = 1'b0;
    low_cnt = 0;
    forever begin
      @(negedge clk);
      if (tx_mode == M_HOLD1) begin
        tx_ready = 1'b1; pend = 1'b0; low_cnt = 0;
      end else if (tx_mode == M_HOLD0) begin
        tx_ready = 1'b0; pend = 1'b0; low_cnt = 0;
      end else begin
        if (pend) begin
          tx_ready = 1'b0; low_cnt = low_len; pend = 1'b0;
        end else if (low_cnt > 0) begin
          low_cnt--;
          if (low_cnt == 0) tx_ready = 1'b1;
        end else begin
          tx_ready = 1'b1;
        end
        if (tx_valid) pend = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [15:0] w);
    in_valid = 1'b1;
    in_data  = w;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic push_pkt();
    for (int i = 0; i < PKT_WORDS; i++) push_word(pkt_words[i]);
  endtask

  task automatic load_bytes(input logic [7:0] b[11]);
    for (int i = 0; i < 11; i++) exp_q.push_back(b[i]);
  endtask

  task automatic wait_pkts(input string tag, input int target, input int budget);
    int n;
    n = 0;
    while (int'(pkt_count) != target && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(pkt_count), 32'(target));
  endtask

  task automatic wait_pulse(input string tag, input int budget);
    int base;
    int n;
    base = n_pulses;
    n = 0;
    while (n_pulses == base && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(n_pulses != base), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  32'(in_ready),   32'd1);
    check({tag, "_tx_valid"},  32'(tx_valid),   32'd0);
    check({tag, "_tx_data"},   32'(tx_data),    32'd0);
    check({tag, "_level"},     32'(fifo_level), 32'd0);
    check({tag, "_overflow"},  32'(overflow),   32'd0);
    check({tag, "_busy"},      32'(busy),       32'd0);
    check({tag, "_pkt_count"}, 32'(pkt_count),  32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int base, push_cyc, t_a, t_b;
    logic [7:0] d_a;

    rst = 1'b1;
    repeat (3) tick();
    check_reset_outputs("rst");
    rst = 1'b0;
    tick();

    // Single packet.
    load_bytes(single_exp);
    pkt_words = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
    push_pkt();
    wait_pkts("single_done", 1, 400);
    tick();
    check("single_all_bytes", 32'(exp_q.size()), 32'd0);
    check("single_pkt_count", 32'(pkt_count), 32'd1);
    check("single_level", 32'(fifo_level), 32'd0);
    check("single_busy", 32'(busy), 32'd0);

    // Partial fill: three words must not start a packet.
    base = n_pulses;
    push_word(16'h0102);
    push_word(16'h0304);
    push_word(16'h0506);
    repeat (1000) tick();
    check("partial_no_valid", 32'(n_pulses - base), 32'd0);
    check("partial_level", 32'(fifo_level), 32'd3);
    check("partial_busy", 32'(busy), 32'd0);
    load_bytes(partial_exp);
    push_cyc = cyc;
    push_word(16'h0708);
    wait_pulse("partial_start", 20);
    check("partial_start_latency", 32'((last_pulse_cyc - push_cyc) <= 3), 32'd1);
    check("partial_first_byte", 32'(pulse_data), 32'hA5);
    wait_pkts("partial_done", 2, 400);
    check("partial_all_bytes", 32'(exp_q.size()), 32'd0);

    // Overflow with the transmitter stalled.
    tx_mode = M_HOLD0;
    repeat (3) tick();
    for (int i = 0; i < 16; i++) push_word(16'h1000 + 16'(i));
    check("ovf_in_ready_full", 32'(in_ready), 32'd0);
    check("ovf_level_full", 32'(fifo_level), 32'd16);
    check("ovf_not_early", 32'(overflow), 32'd0);
    push_word(16'h10FF);
    check("ovf_sticky_set", 32'(overflow), 32'd1);
    check("ovf_level_held", 32'(fifo_level), 32'd16);
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < PKT_WORDS; i++) pkt_words[i] = 16'h1000 + 16'(p * 4 + i);
      sb_load_pkt(8'(p + 2));
    end
    base = n_pulses;
    tx_mode = M_NORMAL;
    wait_pkts("ovf_drain", 6, 3000);
    repeat (50) tick();
    check("ovf_pulses", 32'(n_pulses - base), 32'd44);
    check("ovf_all_bytes", 32'(exp_q.size()), 32'd0);
    check("ovf_level_empty", 32'(fifo_level), 32'd0);
    check("ovf_still_set", 32'(overflow), 32'd1);

    // Acknowledge timeout: tx_ready never falls.
    tx_mode = M_HOLD1;
    sb_en = 1'b0;
    repeat (3) tick();
    pkt_words = '{16'h2001, 16'h2002, 16'h2003, 16'h2004};
    push_pkt();
    wait_pulse("tmo_first", 50);
    t_a = last_pulse_cyc;
    d_a = pulse_data;
    wait_pulse("tmo_second", ACK_TIMEOUT + 50);
    t_b = last_pulse_cyc;
    // Re-pulse lands ACK_TIMEOUT cycles after the cycle following the first pulse.
    check("tmo_interval", 32'(t_b - t_a), 32'(ACK_TIMEOUT + 1));
    check("tmo_data_first", 32'(d_a), 32'hA5);
    check("tmo_data_retry", 32'(pulse_data), 32'hA5);
    check("tmo_busy", 32'(busy), 32'd1);

    // Clean reset, then a packet interrupted by reset after its 4th byte.
    tx_mode = M_NORMAL;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    exp_q.delete();
    sb_en = 1'b1;
    tick();
    pkt_words = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    sb_load_pkt(8'h00);
    base = n_pulses;
    push_pkt();
    begin
      int n;
      n = 0;
      while (n_pulses < base + 4 && n < 300) begin
        tick();
        n++;
      end
    end
    check("midrst_four_bytes", 32'(n_pulses - base), 32'd4);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    check_reset_outputs("midrst");
    rst = 1'b0;
    exp_q.delete();
    base = n_pulses;
    repeat (200) tick();
    check("midrst_silent", 32'(n_pulses - base), 32'd0);

    // Sequence wrap over 257 packets with a fast transmitter.
    low_len = 1;
    for (int p = 1; p <= 257; p++) begin
      for (int i = 0; i < PKT_WORDS; i++) pkt_words[i] = 16'(p * 16 + i * 3 + 1);
      sb_load_pkt(8'(p - 1));
      push_pkt();
      wait_pkts("wrap_pkt_done", p, 200);
      if (p == 1)   check("wrap_seq_first", 32'(last_seq), 32'h00);
      if (p == 256) check("wrap_seq_256", 32'(last_seq), 32'hFF);
      if (p == 257) check("wrap_seq_257", 32'(last_seq), 32'h00);
    end
    repeat (10) tick();
    check("wrap_pkt_count", 32'(pkt_count), 32'd257);
    check("wrap_all_bytes", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
